// File: rtl/fir_serial_pkg.sv
// Shared defaults and helpers for the FIR filter's serial word interfaces.
package fir_serial_pkg;

  localparam int DATA_WIDTH_DEF = 24;
  localparam int FIFO_DEPTH_DEF = 4;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/serial_word_fifo.sv
// Synchronous FIFO with registered storage, wrap-around pointers and an
// occupancy count. The head word is presented combinationally from storage
// (first-word-fall-through), so a word pushed into an empty FIFO is visible
// on the cycle after the push.
//
// Handshake: a pop occurs on a cycle where rd_valid and rd_ready are both
// high. A push is offered on push; it is accepted when the FIFO is not full,
// or when it is full and a pop happens on the same cycle. A rejected push
// raises drop for that cycle and leaves the contents untouched.
module serial_word_fifo
  import fir_serial_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          rd_ready,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          rd_valid,
  output logic                          drop,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push_ok;

  // Flags, handshake qualification and the masked head word.
  always_comb begin
    full     = (count == CNT_DEPTH);
    empty    = (count == '0);
    pop      = !empty && rd_ready;
    push_ok  = push && (!full || pop);
    drop     = push && full && !pop;
    rd_valid = !empty;
    rd_data  = empty ? '0 : mem[rd_ptr];
  end

  // Storage write; contents need no reset because reads are masked when empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver: recovers LSB-first words framed by a strobe on
// the last bit, rejects short frames, and buffers good words in a FIFO with a
// ready/valid output.
module serial_word_rx
  import fir_serial_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_en,
  input  logic                               i_din,
  input  logic                               i_din_valid,
  output logic [DATA_WIDTH-1:0]              o_word,
  output logic                               o_word_valid,
  input  logic                               i_word_ready,
  output logic                               o_frame_err,
  output logic                               o_overflow,
  output logic [count_width(FIFO_DEPTH)-1:0] o_fifo_count
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BCNT_ONE  = BW'(1);
  localparam logic [BW-1:0] BCNT_SAT  = BW'(DATA_WIDTH);
  localparam logic [BW-1:0] BCNT_LAST = BW'(DATA_WIDTH - 1);

  // Bit 0 of the conceptual shift register is shifted out before it is ever
  // part of a captured word, so only bits DATA_WIDTH-1 down to 1 are stored.
  logic [DATA_WIDTH-1:1] sr;
  logic [BW-1:0]         bcnt;
  logic                  strobe;
  logic                  good;
  logic                  fifo_drop;
  logic [DATA_WIDTH-1:0] capture;

  // Strobe qualification, frame-length check and the word being captured.
  always_comb begin
    strobe  = i_en && i_din_valid;
    good    = strobe && (bcnt >= BCNT_LAST);
    capture = {i_din, sr};
  end

  // Shift register: newest bit enters at the top, earliest ends up at bit 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr <= '0;
    end else if (i_en) begin
      sr <= capture[DATA_WIDTH-1:1];
    end
  end

  // Enabled cycles since the last strobe, saturating at DATA_WIDTH.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bcnt <= '0;
    end else if (strobe) begin
      bcnt <= '0;
    end else if (i_en && (bcnt != BCNT_SAT)) begin
      bcnt <= bcnt + BCNT_ONE;
    end
  end

  // Registered one-cycle error pulses for short frames and dropped words.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_frame_err <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_frame_err <= strobe && !good;
      o_overflow  <= fifo_drop;
    end
  end

  serial_word_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (good),
    .push_data (capture),
    .rd_ready  (i_word_ready),
    .rd_data   (o_word),
    .rd_valid  (o_word_valid),
    .drop      (fifo_drop),
    .count     (o_fifo_count)
  );

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: directed scenarios followed by randomized traffic,
// every cycle compared against a bit-queue / word-queue reference model.
module tb_serial_word_rx;
  import fir_serial_pkg::*;

  localparam int DW    = 24;
  localparam int DEPTH = 4;
  localparam int CW    = count_width(DEPTH);

  // Clock and DUT signals
  logic          tb_clk = 1'b0;
  logic          rst;
  logic          en;
  logic          din;
  logic          dv;
  logic          rdy;
  logic [DW-1:0] o_word;
  logic          o_word_valid;
  logic          o_frame_err;
  logic          o_overflow;
  logic [CW-1:0] o_fifo_count;

  always #5 tb_clk = ~tb_clk;

  serial_word_rx #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk        (tb_clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_din        (din),
    .i_din_valid  (dv),
    .o_word       (o_word),
    .o_word_valid (o_word_valid),
    .i_word_ready (rdy),
    .o_frame_err  (o_frame_err),
    .o_overflow   (o_overflow),
    .o_fifo_count (o_fifo_count)
  );

  // Reference model: recent serial bits, words waiting for the consumer,
  // enabled cycles since the last strobe, and the pulses expected now.
  logic [DW-1:0] exp_q[$];
  bit            bit_q[$];
  int            nbits;
  logic          exp_err;
  logic          exp_ovf;
  logic          rand_rdy;

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  task automatic check_outputs();
    logic [DW-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check("word",      32'(o_word),       32'(head));
    check("valid",     32'(o_word_valid), 32'(exp_q.size() > 0));
    check("count",     32'(o_fifo_count), 32'(exp_q.size()));
    check("frame_err", 32'(o_frame_err),  32'(exp_err));
    check("overflow",  32'(o_overflow),   32'(exp_ovf));
  endtask

  task automatic model_clear();
    exp_q.delete();
    bit_q.delete();
    nbits   = 0;
    exp_err = 1'b0;
    exp_ovf = 1'b0;
  endtask

  // The word formed by the last DW received bits, earliest at bit 0; bits
  // never received since reset read as zero.
  function automatic logic [DW-1:0] model_word();
    logic [DW-1:0] w;
    int base;
    base = bit_q.size() - DW;
    for (int i = 0; i < DW; i++) begin
      w[i] = (base + i >= 0) ? bit_q[base + i] : 1'b0;
    end
    return w;
  endfunction

  // One clock cycle: drive, advance the model at the edge, check just after.
  task automatic cycle(input logic e, input logic d, input logic v, input logic r);
    bit pop;
    bit was_full;
    bit good;
    logic [DW-1:0] cap;
    en = e; din = d; dv = v; rdy = r;
    @(posedge tb_clk);
    was_full = (exp_q.size() == DEPTH);
    pop      = (exp_q.size() > 0) && r;
    good     = 1'b0;
    exp_err  = 1'b0;
    exp_ovf  = 1'b0;
    if (e) begin
      bit_q.push_back(d);
      if (bit_q.size() > DW) void'(bit_q.pop_front());
    end
    cap = model_word();
    if (e && v) begin
      if (nbits + 1 >= DW) good = 1'b1;
      else exp_err = 1'b1;
      nbits = 0;
    end else if (e) begin
      nbits++;
    end
    if (pop) void'(exp_q.pop_front());
    if (good) begin
      if (!was_full || pop) exp_q.push_back(cap);
      else exp_ovf = 1'b1;
    end
    #1;
    check_outputs();
  endtask

  function automatic logic pick_rdy(input logic r);
    return rand_rdy ? 1'($urandom_range(0, 1)) : r;
  endfunction

  // Full word, LSB first; optional 3-cycle enable gap before bit gap_at.
  task automatic send_word(input logic [DW-1:0] w, input int gap_at,
                           input logic r_body, input logic r_strobe);
    for (int i = 0; i < DW; i++) begin
      if (i == gap_at) begin
        repeat (3) cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_rdy(r_body));
      end
      cycle(1'b1, w[i], i == DW - 1, pick_rdy((i == DW - 1) ? r_strobe : r_body));
    end
  endtask

  // n random bits with the strobe on the last one.
  task automatic send_bits(input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), i == n - 1, pick_rdy(r));
    end
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    @(posedge tb_clk);
    #1;
    model_clear();
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rand_rdy = 1'b0;
    rst = 1'b1; en = 1'b0; din = 1'b0; dv = 1'b0; rdy = 1'b0;
    model_clear();

    // Reset state
    repeat (2) @(posedge tb_clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Back-to-back words with one idle enabled cycle between them
    send_word(24'h000001, -1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    send_word(24'h800000, -1, 1'b1, 1'b1);
    drain(2);

    // Short frame right after reset, then an intact word
    sync_reset();
    send_bits(10, 1'b1);
    send_word(24'hABCDEF, -1, 1'b1, 1'b1);
    drain(2);

    // Backpressure fills the FIFO, fifth word overflows, then drain in order
    for (int k = 0; k < 5; k++) send_word(DW'(32'h10 + k), -1, 1'b0, 1'b0);
    drain(6);

    // Enable gap mid-word with random activity on the ignored inputs
    send_word(24'h5A5A5A, 12, 1'b1, 1'b1);
    drain(2);

    // Full FIFO, pop coincides with a good strobe
    for (int k = 0; k < 4; k++) send_word(DW'(32'h100 + k), -1, 1'b0, 1'b0);
    send_word(24'h000104, -1, 1'b0, 1'b1);
    drain(6);

    // Async reset mid-word with two words buffered
    send_word(24'h123456, -1, 1'b0, 1'b0);
    send_word(24'h654321, -1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_outputs();
    #1 rst = 1'b0;
    send_bits(DW - 1, 1'b1);
    send_word(24'hC0FFEE, -1, 1'b1, 1'b1);
    drain(2);

    // Randomized traffic: words, short frames, idles, gaps, random ready
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0:       send_bits($urandom_range(1, DW - 1), 1'b0);
        1:       repeat ($urandom_range(1, 4)) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, pick_rdy(1'b0));
        2:       send_word(DW'($urandom), $urandom_range(1, DW - 1), 1'b0, 1'b0);
        default: send_word(DW'($urandom), -1, 1'b0, 1'b0);
      endcase
    end
    rand_rdy = 1'b0;
    drain(DEPTH + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
